frame_buffer_rotator: RTL

//  Parametrised N-buffer (2..4) swap controller; generalises double-buffer swap logic to triple/quad buffering.

---
 rtl/frame_buffer_rotator_pkg.sv | 15 +
 rtl/frame_buffer_rotator_free_buffer_picker.sv | 30 +++
 rtl/frame_buffer_rotator.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/frame_buffer_rotator_pkg.sv
// Shared constants and types for the N-buffer frame rotator.
// Swap-controller FSM states are exported so checkers can bind to them.
package frame_buffer_rotator_pkg;

  localparam int MAX_BUFFERS = 4;

  typedef logic [1:0] buffer_idx_t;

  typedef enum logic [1:0] {
    ROT_RESET   = 2'd0,
    ROT_DRAWING = 2'd1,
    ROT_STALLED = 2'd2
  } rotator_state_t;

endpackage

// File: rtl/frame_buffer_rotator_free_buffer_picker.sv
// Combinational lowest-free-index encoder: returns the lowest buffer index
// not held by the display, the drawer (if valid) or the pending slot (if valid).
module free_buffer_picker #(
  parameter int NUM_BUFFERS = 3,
  parameter int IDX_W       = 2
) (
  input  logic [IDX_W-1:0] display_idx,
  input  logic [IDX_W-1:0] draw_idx,
  input  logic             draw_valid,
  input  logic [IDX_W-1:0] pending_idx,
  input  logic             pending_valid,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_valid
);

  // Scan downwards so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    free_idx   = '0;
    free_valid = 1'b0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (!((IDX_W'(i) == display_idx) ||
            (draw_valid && (IDX_W'(i) == draw_idx)) ||
            (pending_valid && (IDX_W'(i) == pending_idx)))) begin
        free_idx   = IDX_W'(i);
        free_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buffer_rotator.sv
// N-buffer (2..4) swap controller: tracks displayed, drawn and pending buffers,
// with vsync-locked or tearing swaps and drop-oldest when the drawer runs ahead.
module frame_buffer_rotator
  import frame_buffer_rotator_pkg::*;
#(
  parameter int NUM_BUFFERS = 3,
  parameter int IDX_W       = (NUM_BUFFERS > 2) ? 2 : 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vblank_start,
  input  logic             frame_done,
  input  logic             tear_mode,
  output logic [IDX_W-1:0] display_idx,
  output logic [IDX_W-1:0] draw_idx,
  output logic             draw_start,
  output logic             draw_busy,
  output logic             pending_valid,
  output logic [CNT_W-1:0] swap_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             protocol_err,
  output rotator_state_t   state_dbg
);

  if (NUM_BUFFERS < 2 || NUM_BUFFERS > MAX_BUFFERS) begin : g_bad_num_buffers
    $error("frame_buffer_rotator: NUM_BUFFERS must be in 2..4");
  end

  rotator_state_t   state, state_n;
  logic [IDX_W-1:0] pending_idx, pending_idx_n;
  logic [IDX_W-1:0] display_n, draw_n;
  logic             pending_valid_n, draw_start_n, protocol_err_n;
  logic             swap_inc, drop_inc;
  logic [CNT_W-1:0] swap_n, drop_n;

  logic             vb_ok, fd_ok;
  logic [IDX_W-1:0] pick_disp, pick_pend, free_idx;
  logic             pick_pend_valid, free_valid;

  assign draw_busy = (state == ROT_DRAWING);
  assign state_dbg = state;
  assign vb_ok     = vblank_start & ~tear_mode;
  assign fd_ok     = frame_done & draw_busy;

  // Picker sees the display/pending ownership as it will be after this frame_done.
  always_comb begin
    pick_disp       = display_idx;
    pick_pend       = draw_idx;
    pick_pend_valid = 1'b1;
    if (vb_ok && pending_valid) begin
      pick_disp = pending_idx;
    end else if (vb_ok) begin
      pick_disp       = draw_idx;
      pick_pend_valid = 1'b0;
    end
  end

  free_buffer_picker #(
    .NUM_BUFFERS (NUM_BUFFERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .display_idx   (pick_disp),
    .draw_idx      (draw_idx),
    .draw_valid    (1'b0),
    .pending_idx   (pick_pend),
    .pending_valid (pick_pend_valid),
    .free_idx      (free_idx),
    .free_valid    (free_valid)
  );

  always_comb begin
    state_n         = state;
    display_n       = display_idx;
    draw_n          = draw_idx;
    pending_idx_n   = pending_idx;
    pending_valid_n = pending_valid;
    draw_start_n    = 1'b0;
    swap_inc        = 1'b0;
    drop_inc        = 1'b0;
    protocol_err_n  = protocol_err | (frame_done & ~draw_busy);

    case (state)
      ROT_RESET: begin
        state_n      = ROT_DRAWING;
        draw_start_n = 1'b1;
      end
      default: begin
        if (fd_ok && tear_mode) begin
          // Tearing swap: finished buffer goes straight to scan-out.
          display_n       = draw_idx;
          draw_n          = display_idx;
          draw_start_n    = 1'b1;
          swap_inc        = 1'b1;
          drop_inc        = pending_valid;
          pending_valid_n = 1'b0;
        end else if (fd_ok) begin
          if (vb_ok && pending_valid) begin
            display_n     = pending_idx;
            pending_idx_n = draw_idx;
            swap_inc      = 1'b1;
          end else if (vb_ok) begin
            display_n = draw_idx;
            swap_inc  = 1'b1;
          end else begin
            drop_inc        = pending_valid;
            pending_idx_n   = draw_idx;
            pending_valid_n = 1'b1;
          end
          if (free_valid) begin
            draw_n       = free_idx;
            draw_start_n = 1'b1;
            state_n      = ROT_DRAWING;
          end else begin
            state_n = ROT_STALLED;
          end
        end else if (vb_ok && pending_valid) begin
          display_n       = pending_idx;
          pending_valid_n = 1'b0;
          swap_inc        = 1'b1;
          // The buffer leaving scan-out is the one a stalled drawer resumes on.
          if (state == ROT_STALLED) begin
            draw_n       = display_idx;
            draw_start_n = 1'b1;
            state_n      = ROT_DRAWING;
          end
        end
      end
    endcase

    swap_n = (swap_inc && (swap_count != {CNT_W{1'b1}})) ? swap_count + CNT_W'(1) : swap_count;
    drop_n = (drop_inc && (drop_count != {CNT_W{1'b1}})) ? drop_count + CNT_W'(1) : drop_count;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ROT_RESET;
      display_idx   <= IDX_W'(0);
      draw_idx      <= IDX_W'(1);
      pending_idx   <= '0;
      pending_valid <= 1'b0;
      draw_start    <= 1'b0;
      swap_count    <= '0;
      drop_count    <= '0;
      protocol_err  <= 1'b0;
    end else begin
      state         <= state_n;
      display_idx   <= display_n;
      draw_idx      <= draw_n;
      pending_idx   <= pending_idx_n;
      pending_valid <= pending_valid_n;
      draw_start    <= draw_start_n;
      swap_count    <= swap_n;
      drop_count    <= drop_n;
      protocol_err  <= protocol_err_n;
    end
  end

endmodule
